// File: rtl/pe_cfg_pkg.sv
// Shared types for the PE configuration loader: FSM states, output word and FIFO entry layouts.
// The CKSUM state exists only when PE_CFG_CHECKSUM_EN is defined.
package pe_cfg_pkg;

    localparam logic [31:0] START_CMD_DEFAULT = 32'd1;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } cfg_word_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } fifo_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
`ifdef PE_CFG_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_GAP,
        ST_START
    } state_t;

endpackage

// File: rtl/pe_cfg_loader_if.sv
// Host-side valid/ready handshake carrying configuration words and the packet-end flag.
interface pe_cfg_loader_if;

    logic        host_valid;
    logic        host_ready;
    logic [31:0] host_data;
    logic        host_last;

    modport master (output host_valid, output host_data, output host_last, input host_ready);
    modport slave  (input host_valid, input host_data, input host_last, output host_ready);

endinterface

// File: rtl/pe_cfg_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is the current head entry (show-ahead).
module pe_cfg_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; empty pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/pe_cfg_loader.sv
// Buffers host configuration packets and streams them to the PE, followed by a start command.
// Define PE_CFG_CHECKSUM_EN to append an XOR checksum word after each packet.
import pe_cfg_pkg::*;

module pe_cfg_loader #(
    parameter int          DEPTH      = 8,
    parameter int          GAP_CYCLES = 2,
    parameter logic [31:0] START_CMD  = START_CMD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    pe_cfg_loader_if.slave         host,
    input  logic                   cfg_hold,
    output logic [32:0]            PE_Configure_Inport,
    output logic                   cfg_done,
    output logic [7:0]             word_cnt
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t      r_state, w_state_nxt;
    cfg_word_t   r_out, w_out_nxt;
    logic        r_done, w_done_nxt;
    logic [7:0]  r_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic        r_ready_en;
    logic        w_full, w_empty, w_push, w_pop;
    logic        w_cnt_clr, w_cnt_inc, w_gap_clr, w_gap_inc;
    fifo_entry_t w_entry, w_head;
`ifdef PE_CFG_CHECKSUM_EN
    logic [31:0] r_xor;
`endif

    // Ready stays low through reset and rises on the first edge after release.
    assign host.host_ready = r_ready_en & ~w_full;
    assign w_push  = host.host_valid & host.host_ready;
    assign w_entry = '{last: host.host_last, data: host.host_data};

    pe_cfg_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = '{valid: 1'b0, data: r_out.data};
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_gap_clr   = 1'b0;
        w_gap_inc   = 1'b0;
        if (!cfg_hold) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_state_nxt = ST_SEND;
                        w_cnt_clr   = 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_out_nxt = '{valid: 1'b1, data: w_head.data};
                        w_cnt_inc = 1'b1;
                        if (w_head.last) begin
`ifdef PE_CFG_CHECKSUM_EN
                            w_state_nxt = ST_CKSUM;
`else
                            w_state_nxt = (GAP_CYCLES == 0) ? ST_START : ST_GAP;
                            w_gap_clr   = 1'b1;
`endif
                        end
                    end
                end
`ifdef PE_CFG_CHECKSUM_EN
                ST_CKSUM: begin
                    w_out_nxt   = '{valid: 1'b1, data: r_xor};
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = (GAP_CYCLES == 0) ? ST_START : ST_GAP;
                    w_gap_clr   = 1'b1;
                end
`endif
                ST_GAP: begin
                    if (r_gap_cnt == GW'(GAP_CYCLES - 1)) w_state_nxt = ST_START;
                    else                                  w_gap_inc   = 1'b1;
                end
                ST_START: begin
                    w_out_nxt   = '{valid: 1'b1, data: START_CMD};
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out      <= '0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_gap_cnt  <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_out      <= w_out_nxt;
            r_done     <= w_done_nxt;
            if (w_cnt_clr)                        r_cnt <= '0;
            else if (w_cnt_inc && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            if (w_gap_clr)      r_gap_cnt <= '0;
            else if (w_gap_inc) r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

`ifdef PE_CFG_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_xor <= '0;
        else if (w_cnt_clr) r_xor <= '0;
        else if (w_pop)     r_xor <= r_xor ^ w_head.data;
    end
`endif

    assign PE_Configure_Inport = r_out;
    assign cfg_done            = r_done;
    assign word_cnt            = r_cnt;

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Scoreboard bench for pe_cfg_loader: directed packets push expected words, a monitor pops and compares.
module tb_pe_cfg_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_hold;
    logic [32:0] pe_out;
    logic        cfg_done;
    logic [7:0]  word_cnt;

    pe_cfg_loader_if host_if ();

    pe_cfg_loader #(.DEPTH(8), .GAP_CYCLES(2), .START_CMD(32'd1)) dut (
        .clk                 (clk),
        .reset               (reset),
        .host                (host_if),
        .cfg_hold            (cfg_hold),
        .PE_Configure_Inport (pe_out),
        .cfg_done            (cfg_done),
        .word_cnt            (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] word;
        logic        done;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        exp_e;
    int          stamps [$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    logic [31:0] last_data = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void exp_word(input logic [31:0] d);
        exp_q.push_back('{word: {1'b1, d}, done: 1'b0});
    endfunction

    function automatic void exp_cksum(input logic [31:0] d);
`ifdef PE_CFG_CHECKSUM_EN
        exp_q.push_back('{word: {1'b1, d}, done: 1'b0});
`else
        if (d == 32'hFFFF_FFFF) exp_q.push_back('{word: 33'h0, done: 1'b0}); // never taken
`endif
    endfunction

    function automatic void exp_start();
        exp_q.push_back('{word: {1'b1, 32'd1}, done: 1'b1});
    endfunction

    // Monitor: every valid output word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (reset) begin
            last_data = '0;
        end else if (pe_out[32]) begin
            stamps.push_back(cyc);
            if (cfg_done) done_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %h required no output", pe_out);
            end else begin
                exp_e = exp_q.pop_front();
                check("out_word", pe_out, exp_e.word);
                check("out_done", {32'b0, cfg_done}, {32'b0, exp_e.done});
            end
            last_data = pe_out[31:0];
        end else begin
            check("idle_data_held", {1'b0, pe_out[31:0]}, {1'b0, last_data});
            check("idle_no_done", {32'b0, cfg_done}, 33'd0);
        end
    end

    task automatic push_word(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        host_if.host_valid = 1'b1;
        host_if.host_data  = d;
        host_if.host_last  = l;
        while (!host_if.host_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: got ready=0 required ready=1 for word %h", d);
        end else begin
            @(posedge clk); #1;
        end
        host_if.host_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_q.size(), 33'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_words(input int want);
        int seen, n;
        seen = 0;
        n = 0;
        while (seen < want && n < 200) begin
            @(posedge clk); #1;
            if (pe_out[32]) seen++;
            n++;
        end
        check("wait_words", seen, want);
    endtask

    int d0, n_before;

    initial begin
        reset              = 1'b1;
        cfg_hold           = 1'b0;
        host_if.host_valid = 1'b0;
        host_if.host_data  = '0;
        host_if.host_last  = 1'b0;
        #1;
        check("rst_out", pe_out, 33'd0);
        check("rst_ready", {32'b0, host_if.host_ready}, 33'd0);
        check("rst_cnt", {25'b0, word_cnt}, 33'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_before_edge", {32'b0, host_if.host_ready}, 33'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {32'b0, host_if.host_ready}, 33'd1);

        // Basic packet and gap timing.
        stamps.delete();
        d0 = done_cnt;
        exp_word(32'hA); exp_word(32'hB); exp_word(32'hC); exp_cksum(32'hD); exp_start();
        push_word(32'hA, 1'b0);
        push_word(32'hB, 1'b0);
        push_word(32'hC, 1'b1);
        drain("drain_basic");
`ifdef PE_CFG_CHECKSUM_EN
        check("basic_cnt", {25'b0, word_cnt}, 33'd4);
        check("basic_nstamps", stamps.size(), 33'd5);
        if (stamps.size() == 5) begin
            check("basic_t1", stamps[1] - stamps[0], 33'd1);
            check("basic_t2", stamps[2] - stamps[0], 33'd2);
            check("basic_tck", stamps[3] - stamps[0], 33'd3);
            check("basic_tstart", stamps[4] - stamps[0], 33'd6);
        end
`else
        check("basic_cnt", {25'b0, word_cnt}, 33'd3);
        check("basic_nstamps", stamps.size(), 33'd4);
        if (stamps.size() == 4) begin
            check("basic_t1", stamps[1] - stamps[0], 33'd1);
            check("basic_t2", stamps[2] - stamps[0], 33'd2);
            check("basic_tstart", stamps[3] - stamps[0], 33'd5);
        end
`endif
        check("basic_done_pulses", done_cnt - d0, 33'd1);

        // Fill to full under hold; ninth word waits for the hold to drop.
        stamps.delete();
        cfg_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_word(32'h100 + i);
            push_word(32'h100 + i, 1'b0);
        end
        check("full_ready_low", {32'b0, host_if.host_ready}, 33'd0);
        exp_word(32'h108); exp_cksum(32'h108); exp_start();
        host_if.host_valid = 1'b1;
        host_if.host_data  = 32'h108;
        host_if.host_last  = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("full_held_ready", {32'b0, host_if.host_ready}, 33'd0);
        end
        check("full_no_output", stamps.size(), 33'd0);
        cfg_hold = 1'b0;
        push_word(32'h108, 1'b1);
        drain("drain_full");
`ifdef PE_CFG_CHECKSUM_EN
        check("full_cnt", {25'b0, word_cnt}, 33'd10);
`else
        check("full_cnt", {25'b0, word_cnt}, 33'd9);
`endif

        // Hold for 4 cycles in the middle of a packet.
        cfg_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_word(32'h200 + i);
            push_word(32'h200 + i, i == 5);
        end
        exp_cksum(32'h001); exp_start();
        cfg_hold = 1'b0;
        wait_valid_words(2);
        cfg_hold = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("hold_valid_low", {32'b0, pe_out[32]}, 33'd0);
        end
        check("hold_cnt_frozen", {25'b0, word_cnt}, 33'd2);
        cfg_hold = 1'b0;
        drain("drain_hold");

        // FIFO starved mid-packet: no start command until the last word.
        d0 = done_cnt;
        exp_word(32'h400); exp_word(32'h401);
        push_word(32'h400, 1'b0);
        push_word(32'h401, 1'b0);
        wait_valid_words(2);
        repeat (3) begin
            @(posedge clk); #1;
            check("starve_valid_low", {32'b0, pe_out[32]}, 33'd0);
            check("starve_cnt", {25'b0, word_cnt}, 33'd2);
        end
        check("starve_no_done", done_cnt - d0, 33'd0);
        exp_word(32'h402); exp_cksum(32'h403); exp_start();
        push_word(32'h402, 1'b1);
        drain("drain_starve");
        check("starve_done", done_cnt - d0, 33'd1);

        // Checksum packet (checksum word only appears when enabled).
        exp_word(32'h0F); exp_word(32'hF0); exp_cksum(32'hFF); exp_start();
        push_word(32'h0F, 1'b0);
        push_word(32'hF0, 1'b1);
        drain("drain_cksum");

        // word_cnt saturates at 255.
        for (int i = 0; i < 256; i++) exp_word(i);
        exp_cksum(32'h0); exp_start();
        for (int i = 0; i < 256; i++) push_word(i, i == 255);
        drain("drain_sat");
        check("sat_cnt", {25'b0, word_cnt}, 33'd255);

        // Reset after 2 of 5 buffered words have been emitted.
        cfg_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_word(32'h300 + i);
            push_word(32'h300 + i, i == 4);
        end
        cfg_hold = 1'b0;
        wait_valid_words(2);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_out", pe_out, 33'd0);
        check("midrst_done", {32'b0, cfg_done}, 33'd0);
        check("midrst_cnt", {25'b0, word_cnt}, 33'd0);
        check("midrst_ready", {32'b0, host_if.host_ready}, 33'd0);
        n_before = stamps.size();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready_up", {32'b0, host_if.host_ready}, 33'd1);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_resume", stamps.size(), n_before);
        check("midrst_out_idle", pe_out, 33'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_cfg_loader.md
PE_CFG_LOADER -- requirements
Module: pe_cfg_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 8: configuration FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: idle cycles between a packet's last word and the start command.
REQ-003 SHALL have parameter START_CMD, default 32'd1: start command word sent after each packet.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port host_valid, input, 1: host offers a configuration word.
REQ-007 SHALL have port host_ready, output, 1: the loader accepts a word this cycle.
REQ-008 SHALL have port host_data, input, 32: the configuration word.
REQ-009 SHALL have port host_last, input, 1: this word ends the packet.
REQ-010 SHALL have port cfg_hold, input, 1: the PE is not ready for configuration; stall emission.
REQ-011 SHALL have port PE_Configure_Inport, output, 33: bit 32 is the word-valid bit; bits 31:0 are the word.
REQ-012 SHALL have port cfg_done, output, 1: one-cycle pulse when the start command is emitted.
REQ-013 SHALL have port word_cnt, output, 8: number of words emitted in the current packet, saturating at 255.

Function
REQ-014 SHALL push {host_last, host_data} into the FIFO when host_valid and host_ready are both high; host_ready = FIFO not full.
REQ-015 SHALL keep host_ready low when the FIFO is full, even if a pop happens in the same cycle (no same-cycle pass-through at full).
REQ-016 SHALL register PE_Configure_Inport; a word pushed in cycle N appears on the output no earlier than cycle N+1.
REQ-017 SHALL implement the states IDLE, SEND, CKSUM, GAP and START.
REQ-018 IDLE: output bit 32 = 0; SHALL go to SEND when the FIFO is not empty and cfg_hold is low; SHALL clear word_cnt on that transition.
REQ-019 SEND: each cycle the FIFO is not empty and cfg_hold is low, SHALL pop one entry, drive {1'b1, word} and increment word_cnt.
REQ-020 SEND, FIFO empty mid-packet: SHALL drive bit 32 = 0 and stay in SEND.
REQ-021 SEND: on popping an entry with last = 1, SHALL go to CKSUM if the macro is defined, otherwise to GAP.
REQ-022 GAP: SHALL drive bit 32 = 0 for exactly GAP_CYCLES unheld cycles, then go to START; GAP_CYCLES = 0 SHALL go directly to START.
REQ-023 START: SHALL drive {1'b1, START_CMD}, pulse cfg_done for one cycle, and return to IDLE.
REQ-024 While cfg_hold is high, bit 32 SHALL be 0 in every state, and state, counters and FIFO pop SHALL freeze; FIFO push continues.
REQ-025 When bit 32 = 0, bits 31:0 SHALL hold their previous value.
REQ-026 SHALL wrap the FIFO read and write pointers modulo DEPTH and use an extra wrap bit to tell full from empty.

Reset
REQ-027 On reset assertion, without waiting for a clock edge: PE_Configure_Inport = 33'b0, cfg_done = 0, word_cnt = 0, state = IDLE, FIFO empty, host_ready = 0.
REQ-028 host_ready SHALL rise on the first clock edge after reset deasserts.
REQ-029 Reset asserted mid-packet SHALL discard all buffered words; no partial packet resumes afterwards.

Configuration
REQ-030 With PE_CFG_CHECKSUM_EN defined, CKSUM SHALL emit {1'b1, XOR of all data words in the packet} before GAP; word_cnt SHALL count this word.
REQ-031 Without PE_CFG_CHECKSUM_EN, there SHALL be no CKSUM state and no XOR accumulator; SEND goes directly to GAP.

Structure
REQ-032 The state encoding, the 33-bit config word layout and the START_CMD default SHALL live in shared package pe_cfg_pkg.
REQ-033 The FIFO SHALL be a single sub-module, pe_cfg_fifo (parameterized width and depth; push/pop, full/empty).

Verification
REQ-034 Push 3 words (0xA, 0xB, 0xC, last on 0xC), cfg_hold = 0 -> output valid words 0xA, 0xB, 0xC on consecutive cycles, 2 idle cycles, then {1, 0x1}; cfg_done pulses once; word_cnt = 3.
REQ-035 Push 9 words with DEPTH = 8 and no pops (cfg_hold = 1) -> host_ready low after 8 accepts; the 9th word is accepted only after cfg_hold drops.
REQ-036 Raise cfg_hold for 4 cycles mid-packet -> bit 32 = 0 for those 4 cycles; sequence resumes with no word lost or duplicated.
REQ-037 Assert reset after 2 of 5 words are emitted -> output 33'b0 immediately; after release, bit 32 stays 0 with no host traffic.
REQ-038 With PE_CFG_CHECKSUM_EN, send packet 0x0F, 0xF0 -> words 0x0F, 0xF0, 0xFF, then the start command.
REQ-039 Starve the FIFO mid-packet for 3 cycles -> bit 32 = 0 and state stays SEND; no start command until the last word is sent.
